// File: rtl/user_bpss_wr_pkg.sv
// Shared types and constants for the write-side bypass engine: the request
// descriptor, engine states and the length-to-beat conversion.
package user_bpss_wr_pkg;

    localparam int BEAT_B           = 64;
    localparam int BEAT_SH          = $clog2(BEAT_B);
    localparam int DATA_BITS        = BEAT_B * 8;
    localparam int TID_BITS         = 6;
    localparam int BPSS_WR_MAX_OUTS = 8;

    localparam int LEN_BITS   = 28;
    localparam int VADDR_BITS = 48;
    localparam int CTL_BITS   = 8;
    // One extra bit so a maximal length that is not beat-aligned still fits.
    localparam int BEAT_CNT_BITS = LEN_BITS - BEAT_SH + 1;

    typedef struct packed {
        logic [CTL_BITS-1:0]   ctl;
        logic [LEN_BITS-1:0]   len;
        logic [VADDR_BITS-1:0] vaddr;
    } req_t;

    localparam int REQ_BITS = $bits(req_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA
    } state_t;

    function automatic logic [BEAT_CNT_BITS-1:0] beat_cnt(input logic [LEN_BITS-1:0] len);
        return {1'b0, len[LEN_BITS-1:BEAT_SH]} + BEAT_CNT_BITS'(len[BEAT_SH-1:0] != '0);
    endfunction

endpackage

// File: rtl/user_bpss_wr_arb.sv
// Round-robin arbiter: the search starts one past the last source granted,
// and the pointer moves only when the caller consumes the grant.
module user_bpss_wr_arb #(
    parameter int N_SRC = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_SRC-1:0] req,
    input  logic             advance,
    output logic [N_SRC-1:0] grant
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt    = (idx == N_SRC - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/user_bpss_wr.sv
// Write-side bypass engine: arbitrates source requests, issues one descriptor
// at a time and forwards the granted source stream, framed by beat count.
module user_bpss_wr
    import user_bpss_wr_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int MAX_OUTS = BPSS_WR_MAX_OUTS
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_SRC-1:0]              s_req_valid,
    output logic [N_SRC-1:0]              s_req_ready,
    input  logic [N_SRC*REQ_BITS-1:0]     s_req_data,
    input  logic [N_SRC-1:0]              s_axis_tvalid,
    output logic [N_SRC-1:0]              s_axis_tready,
    input  logic [N_SRC*DATA_BITS-1:0]    s_axis_tdata,
    input  logic [N_SRC*BEAT_B-1:0]       s_axis_tkeep,
    input  logic [N_SRC*TID_BITS-1:0]     s_axis_tid,
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [REQ_BITS-1:0]           m_req_data,
    input  logic                          s_done_valid,
    output logic                          s_done_ready,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic [BEAT_B-1:0]             m_axis_tkeep,
    output logic [TID_BITS-1:0]           m_axis_tid,
    output logic                          m_axis_tlast,
    output logic [3:0]                    outs_cnt,
    output logic [31:0]                   done_cnt,
    output logic                          err_zero
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_t                   state;
    req_t                     req_q;
    req_t                     grant_req;
    logic [IDX_W-1:0]         sel;
    logic [IDX_W-1:0]         grant_idx;
    logic [N_SRC-1:0]         grant;
    logic [BEAT_CNT_BITS-1:0] beats_left;
    logic                     can_grant;
    logic                     take;
    logic                     issue;
    logic                     beat;
    logic                     done_dec;

    assign can_grant = aresetn && (state == ST_IDLE) && (outs_cnt < 4'(MAX_OUTS));

    user_bpss_wr_arb #(.N_SRC(N_SRC)) u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (s_req_valid & {N_SRC{can_grant}}),
        .advance (take),
        .grant   (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    assign take         = |grant;
    assign s_req_ready  = grant;
    assign grant_req    = req_t'(s_req_data[int'(grant_idx)*REQ_BITS +: REQ_BITS]);
    assign m_req_data   = req_q;
    assign issue        = (state == ST_REQ) && m_req_ready;
    assign s_done_ready = 1'b1;
    assign done_dec     = s_done_valid && (outs_cnt != '0);

    // Stream path is pure wiring so a ready source moves a beat every cycle.
    assign m_axis_tvalid = (state == ST_DATA) && s_axis_tvalid[sel];
    assign m_axis_tdata  = s_axis_tdata[int'(sel)*DATA_BITS +: DATA_BITS];
    assign m_axis_tkeep  = s_axis_tkeep[int'(sel)*BEAT_B +: BEAT_B];
    assign m_axis_tid    = s_axis_tid[int'(sel)*TID_BITS +: TID_BITS];
    assign m_axis_tlast  = (state == ST_DATA) && (beats_left == BEAT_CNT_BITS'(1));
    assign beat          = m_axis_tvalid && m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        if (state == ST_DATA) s_axis_tready[sel] = m_axis_tready;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            // NOTE: the descriptor register is cleared too so m_req_data never shows X.
            req_q       <= '0;
            sel         <= '0;
            beats_left  <= '0;
            m_req_valid <= 1'b0;
            err_zero    <= 1'b0;
        end else begin
            err_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        sel   <= grant_idx;
                        req_q <= grant_req;
                        if (grant_req.len == '0) begin
                            err_zero <= 1'b1;
                        end else begin
                            state       <= ST_REQ;
                            m_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (m_req_ready) begin
                        m_req_valid <= 1'b0;
                        beats_left  <= beat_cnt(req_q.len);
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        beats_left <= beats_left - BEAT_CNT_BITS'(1);
                        if (beats_left == BEAT_CNT_BITS'(1)) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completion with nothing outstanding still counts but cannot underflow.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            outs_cnt <= '0;
            done_cnt <= '0;
        end else begin
            if (issue && !done_dec) outs_cnt <= outs_cnt + 4'd1;
            else if (!issue && done_dec) outs_cnt <= outs_cnt - 4'd1;
            if (s_done_valid) done_cnt <= done_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_user_bpss_wr.sv
// Randomized bench for user_bpss_wr: source agents, random sinks and a
// transaction-level reference model checked on every falling edge.
module tb_user_bpss_wr;
    import user_bpss_wr_pkg::*;

    localparam int N_SRC = 2;
    localparam int MAXO  = BPSS_WR_MAX_OUTS;

    logic                       aclk = 1'b0;
    logic                       aresetn = 1'b0;
    logic [N_SRC-1:0]           s_req_valid, s_req_ready;
    logic [N_SRC*REQ_BITS-1:0]  s_req_data;
    logic [N_SRC-1:0]           s_axis_tvalid, s_axis_tready;
    logic [N_SRC*DATA_BITS-1:0] s_axis_tdata;
    logic [N_SRC*BEAT_B-1:0]    s_axis_tkeep;
    logic [N_SRC*TID_BITS-1:0]  s_axis_tid;
    logic                       m_req_valid, m_req_ready;
    logic [REQ_BITS-1:0]        m_req_data;
    logic                       s_done_valid, s_done_ready;
    logic                       m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DATA_BITS-1:0]       m_axis_tdata;
    logic [BEAT_B-1:0]          m_axis_tkeep;
    logic [TID_BITS-1:0]        m_axis_tid;
    logic [3:0]                 outs_cnt;
    logic [31:0]                done_cnt;
    logic                       err_zero;

    always #5 aclk = ~aclk;

    user_bpss_wr #(.N_SRC(N_SRC)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req_data    (s_req_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tid    (s_axis_tid),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req_data    (m_req_data),
        .s_done_valid  (s_done_valid),
        .s_done_ready  (s_done_ready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .outs_cnt      (outs_cnt),
        .done_cnt      (done_cnt),
        .err_zero      (err_zero)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DATA_BITS-1:0] got,
                         input logic [DATA_BITS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Agent and model state
    req_t       req_q[N_SRC][$];
    bit         offer[N_SRC];
    int         seq[N_SRC];
    int         rr_ptr;
    bit         pend;
    req_t       pend_req;
    int         pend_src;
    bit         act;
    int         act_src, act_total, act_sent;
    int         outs;
    logic [31:0] dones;
    bit         err_exp;

    int p_req = 70, p_tvalid = 80, p_mreq = 70, p_tready = 80, p_done = 20;
    bit done_pulse = 1'b0;
    bit rst_req = 1'b1;
    bit auto_push = 1'b0;

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic logic [DATA_BITS-1:0] beat_data(input int src, input int s);
        logic [31:0] w;
        w = {4'(src), 28'(s)};
        return {16{w}};
    endfunction

    function automatic logic [BEAT_B-1:0] beat_keep(input int src, input int s);
        return {~32'(s), 32'(s + src * 1000)};
    endfunction

    function automatic req_t mk_req(input int len);
        req_t r;
        r.ctl   = 8'($urandom);
        r.len   = 28'(len);
        r.vaddr = {16'($urandom), 32'($urandom)};
        return r;
    endfunction

    function automatic int rand_len();
        case ($urandom_range(5))
            0:       return 0;
            1:       return 64;
            2:       return 100;
            3:       return 256;
            default: return $urandom_range(400, 1);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_SRC; i++) begin
            req_q[i].delete();
            offer[i] = 1'b0;
        end
        rr_ptr  = 0;
        pend    = 1'b0;
        act     = 1'b0;
        outs    = 0;
        dones   = '0;
        err_exp = 1'b0;
    endtask

    task automatic drive();
        aresetn = !rst_req;
        for (int i = 0; i < N_SRC; i++) begin
            if (!offer[i] && req_q[i].size() > 0 && rnd(p_req)) offer[i] = 1'b1;
            s_req_valid[i] = offer[i];
            s_req_data[i*REQ_BITS +: REQ_BITS] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
            s_axis_tvalid[i] = rnd(p_tvalid);
            s_axis_tdata[i*DATA_BITS +: DATA_BITS] = beat_data(i, seq[i]);
            s_axis_tkeep[i*BEAT_B +: BEAT_B] = beat_keep(i, seq[i]);
            s_axis_tid[i*TID_BITS +: TID_BITS] = TID_BITS'(i);
        end
        m_req_ready   = rnd(p_mreq);
        m_axis_tready = rnd(p_tready);
        s_done_valid  = done_pulse || rnd(p_done);
        done_pulse    = 1'b0;
    endtask

    // Compare this cycle's outputs to the model, then advance the model
    // by the handshakes that the coming edge will complete.
    task automatic monitor();
        logic [N_SRC-1:0] exp_rdy, exp_trdy;
        int  pick;
        bit  idle, inc, dec;
        req_t r;
        idle = !pend && !act;
        pick = -1;
        if (idle && outs < MAXO) begin
            for (int k = 0; k < N_SRC; k++) begin
                int j;
                j = (rr_ptr + k) % N_SRC;
                if (pick < 0 && s_req_valid[j]) pick = j;
            end
        end
        exp_rdy = '0;
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        check("s_req_ready", s_req_ready, exp_rdy);
        check("m_req_valid", m_req_valid, pend);
        if (pend) check("m_req_data", m_req_data, pend_req);
        check("outs_cnt", outs_cnt, outs);
        check("done_cnt", done_cnt, dones);
        check("err_zero", err_zero, err_exp);
        check("s_done_ready", s_done_ready, 1'b1);
        exp_trdy = '0;
        if (act) begin
            exp_trdy[act_src] = m_axis_tready;
            check("m_axis_tvalid", m_axis_tvalid, s_axis_tvalid[act_src]);
            if (s_axis_tvalid[act_src] && m_axis_tready) begin
                check("m_axis_tdata", m_axis_tdata, beat_data(act_src, seq[act_src]));
                check("m_axis_tkeep", m_axis_tkeep, beat_keep(act_src, seq[act_src]));
                check("m_axis_tid", m_axis_tid, TID_BITS'(act_src));
                check("m_axis_tlast", m_axis_tlast, act_sent == act_total - 1);
            end
        end else begin
            check("m_axis_tvalid", m_axis_tvalid, 1'b0);
        end
        check("s_axis_tready", s_axis_tready, exp_trdy);

        // model advance
        for (int i = 0; i < N_SRC; i++)
            if (s_axis_tvalid[i] && s_axis_tready[i]) seq[i]++;
        inc = 1'b0;
        err_exp = 1'b0;
        if (act && s_axis_tvalid[act_src] && m_axis_tready) begin
            act_sent++;
            if (act_sent == act_total) act = 1'b0;
        end
        if (pend && m_req_ready) begin
            pend      = 1'b0;
            inc       = 1'b1;
            act       = 1'b1;
            act_src   = pend_src;
            act_sent  = 0;
            act_total = (int'(pend_req.len) + BEAT_B - 1) / BEAT_B;
        end
        if (pick >= 0) begin
            r = req_q[pick].pop_front();
            offer[pick] = 1'b0;
            rr_ptr = (pick + 1) % N_SRC;
            if (r.len == 0) begin
                err_exp = 1'b1;
            end else begin
                pend     = 1'b1;
                pend_req = r;
                pend_src = pick;
            end
        end
        dec = s_done_valid && outs > 0;
        outs = outs + int'(inc) - int'(dec);
        if (s_done_valid) dones = dones + 32'd1;
    endtask

    task automatic step();
        @(negedge aclk);
        if (aresetn) monitor();
        @(posedge aclk);
        if (!aresetn) model_reset();
        if (auto_push) begin
            int s;
            s = $urandom_range(N_SRC - 1);
            if (rnd(15) && req_q[s].size() < 3) req_q[s].push_back(mk_req(rand_len()));
        end
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int budget;
        bit busy;
        auto_push = 1'b0;
        p_done = 50;
        budget = 3000;
        busy = 1'b1;
        while (busy && budget > 0) begin
            step();
            budget--;
            busy = pend || act || outs != 0;
            for (int i = 0; i < N_SRC; i++) if (req_q[i].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: engine still busy, outs model %0d", outs);
        end
    endtask

    initial begin
        for (int i = 0; i < N_SRC; i++) seq[i] = 0;
        model_reset();
        drive();
        run(3);
        rst_req = 1'b0;
        run(2);

        // single long request on source 0
        req_q[0].push_back(mk_req(256));
        p_done = 0;
        run(40);
        check("single_outs", outs_cnt, 1);
        drain();

        // both sources valid: round-robin order, then a reissue
        p_req = 100;
        req_q[0].push_back(mk_req(64));
        req_q[0].push_back(mk_req(64));
        req_q[1].push_back(mk_req(64));
        run(40);
        drain();

        // partial last beat and zero-length drop
        req_q[1].push_back(mk_req(100));
        req_q[0].push_back(mk_req(0));
        run(40);
        drain();

        // random traffic
        p_req = 70; p_done = 20;
        auto_push = 1'b1;
        run(400);
        drain();

        // saturate outstanding count, then release one slot
        p_done = 0; p_mreq = 100; p_tready = 100; p_tvalid = 100; p_req = 100;
        for (int i = 0; i < 9; i++) req_q[0].push_back(mk_req(64));
        run(60);
        check("stall_outs", outs_cnt, MAXO);
        check("stall_ready", s_req_ready, 0);
        done_pulse = 1'b1;
        run(20);
        check("refill_outs", outs_cnt, MAXO);
        drain();

        // reset in the middle of a 4-beat transfer
        p_done = 0;
        req_q[1].push_back(mk_req(256));
        begin
            int budget;
            budget = 100;
            while (!(act && act_sent == 1) && budget > 0) begin
                step();
                budget--;
            end
            if (budget == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rst_wait: transfer never reached beat 2");
            end
        end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        step();
        check("rst_m_axis_tvalid", m_axis_tvalid, 0);
        check("rst_m_req_valid", m_req_valid, 0);
        check("rst_outs", outs_cnt, 0);
        check("rst_done", done_cnt, 0);

        // more random traffic with busy sinks
        p_mreq = 60; p_tready = 70; p_tvalid = 75; p_req = 70; p_done = 25;
        auto_push = 1'b1;
        run(400);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
